// File: rtl/operand_loader.sv
// operand_loader: pushbutton front end for the arithmetic datapath.
// Synchronizes and debounces key_n. On each clean press it captures the
// switch operands and the operation select, then issues a one-cycle start
// pulse followed by a busy hold window. It also counts accepted presses.
// Optional feature: define AUTO_REPEAT_EN to re-issue the press every
// REPEAT_CYCLES while the key stays held after the hold window.
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_n,
  input  logic [7:0] sw_a,
  input  logic [7:0] sw_b,
  input  logic [4:0] sw_sel,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [4:0] sel,
  output logic       start,
  output logic       busy,
  output logic [7:0] press_count
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, HOLD, WAIT_REL} state_t;

  logic           key_p0, key_p1;
  logic           deb, deb_d;
  logic [DBW-1:0] db_cnt;
  logic [HW-1:0]  hold_cnt;
  logic           rel_seen;
  logic           press_evt, release_evt;
  state_t         state;

  // Debounced edges: press is the 1->0 transition, release the 0->1.
  assign press_evt   = deb_d & ~deb;
  assign release_evt = ~deb_d & deb;

  // Two-flop synchronizer for the asynchronous key, idling released.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
    end else begin
      key_p0 <= key_n;
      key_p1 <= key_p0;
    end
  end

  // Debounce: the key state follows the sample only after DEBOUNCE_CYCLES differing samples in a row.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      deb    <= 1'b1;
      deb_d  <= 1'b1;
      db_cnt <= '0;
    end else begin
      deb_d <= deb;
      if (key_p1 == deb) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        deb    <= key_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_cnt;
`endif

  // Control FSM: capture on press, pulse start, hold busy, then wait for release.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      a           <= '0;
      b           <= '0;
      sel         <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      press_count <= '0;
      hold_cnt    <= '0;
      rel_seen    <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (press_evt) begin
            a           <= sw_a;
            b           <= sw_b;
            sel         <= sw_sel;
            press_count <= press_count + 8'd1;
            start       <= 1'b1;
            busy        <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          start    <= 1'b0;
          hold_cnt <= HOLD_LAST;
          rel_seen <= 1'b0;
          state    <= HOLD;
        end
        HOLD: begin
          // A release seen during the hold window is kept so it is not lost.
          if (release_evt) rel_seen <= 1'b1;
          if (hold_cnt == '0) begin
            busy <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt <= '0;
`endif
            if (rel_seen || release_evt || deb) state <= IDLE;
            else                                state <= WAIT_REL;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        WAIT_REL: begin
          if (deb) begin
            state <= IDLE;
`ifdef AUTO_REPEAT_EN
            rep_cnt <= '0;
          end else if (rep_cnt == REP_LAST) begin
            a           <= sw_a;
            b           <= sw_b;
            sel         <= sw_sel;
            press_count <= press_count + 8'd1;
            start       <= 1'b1;
            busy        <= 1'b1;
            rep_cnt     <= '0;
            state       <= START;
          end else begin
            rep_cnt <= rep_cnt + RW'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
